pipeline_valid_ctrl: RTL and testbench

- Consumer side of the hazard unit's stall/flush/forward protocol. Applies set_invalid_*, stop_IF, stop_ID and redirect requests to the per-stage valid bits, the fetch PC and the per-stage PC registers.
- Drives EX_invalid, MEM_invalid, ID_PC and EX_PC back to the hazard unit, closing the loop.
- Also keeps the cycle and retired-instruction counters used by the CSR file.

---
 rtl/pipeline_valid_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_valid_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_valid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_valid_ctrl
// Description : Pipeline valid/PC controller. Applies hazard-unit kill, stall
//               and redirect requests to per-stage valid bits, the fetch PC
//               and per-stage PCs. Also keeps the mcycle/minstret counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_valid_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_invalid_IF,
  input  logic        set_invalid_ID,
  input  logic        set_invalid_EX,
  input  logic        set_invalid_MEM,
  input  logic        stop_IF,
  input  logic        stop_ID,
  input  logic        took_branch,
  input  logic [31:0] branch_target,
  input  logic        any_excep,
  input  logic [31:0] trap_vector,
  input  logic        ret,
  input  logic [31:0] ret_target,
  input  logic        imem_ready,
  input  logic        dmem_busy,
  output logic [31:0] PC_IF,
  output logic [31:0] ID_PC,
  output logic [31:0] EX_PC,
  output logic [31:0] MEM_PC,
  output logic        ID_invalid,
  output logic        EX_invalid,
  output logic        MEM_invalid,
  output logic        WB_invalid,
  output logic        en_IF_ID,
  output logic        en_ID_EX,
  output logic        en_EX_MEM,
  output logic        en_MEM_WB,
  output logic        retire,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  localparam logic [31:0] C_PC_STEP = 32'(PC_STEP);

  logic        r_if_valid;
  logic        r_id_v;
  logic        r_ex_v;
  logic        r_mem_v;
  logic        r_wb_v;
  logic [31:0] r_pc_if;
  logic [31:0] r_id_pc;
  logic [31:0] r_ex_pc;
  logic [31:0] r_mem_pc;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic        w_freeze;
  logic        w_redirect;
  logic        w_fetch_adv;
  logic        w_retire;
  logic [31:0] w_pc_next;

  // A data-memory stall freezes every stage; redirects are held off with it.
  assign w_freeze    = dmem_busy;
  assign w_redirect  = took_branch | any_excep | ret;
  // stop_ID implies the fetch stalls as well, even if stop_IF is low.
  assign w_fetch_adv = ~stop_IF & ~stop_ID & imem_ready & r_if_valid;
  assign w_retire    = r_wb_v & ~w_freeze;

  // Next fetch PC: branch beats trap beats mret; any redirect beats a stall.
  always_comb begin
    w_pc_next = r_pc_if;
    if (took_branch) begin
      w_pc_next = branch_target;
    end else if (any_excep) begin
      w_pc_next = trap_vector;
    end else if (ret) begin
      w_pc_next = ret_target;
    end else if (w_fetch_adv) begin
      w_pc_next = r_pc_if + C_PC_STEP;
    end
  end

  // Fetch PC and IF valid; IF becomes valid on the first edge out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_if    <= RESET_PC;
      r_if_valid <= 1'b0;
    end else begin
      r_if_valid <= 1'b1;
      if (!w_freeze) begin
        r_pc_if <= w_pc_next;
      end
    end
  end

  // Stage valid bits; a held ID can still be killed, and a held ID feeds a bubble to EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_v  <= 1'b0;
      r_ex_v  <= 1'b0;
      r_mem_v <= 1'b0;
      r_wb_v  <= 1'b0;
    end else if (!w_freeze) begin
      r_wb_v  <= r_mem_v & ~set_invalid_MEM;
      r_mem_v <= r_ex_v & ~set_invalid_EX;
      r_ex_v  <= r_id_v & ~set_invalid_ID & ~stop_ID;
      if (stop_ID) begin
        r_id_v <= r_id_v & ~set_invalid_ID;
      end else begin
        r_id_v <= r_if_valid & imem_ready & ~stop_IF & ~set_invalid_IF & ~w_redirect;
      end
    end
  end

  // Per-stage PCs follow their register enables; bubbles carry a stale PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_pc  <= 32'h0;
      r_ex_pc  <= 32'h0;
      r_mem_pc <= 32'h0;
    end else if (!w_freeze) begin
      if (!stop_ID) begin
        r_id_pc <= r_pc_if;
      end
      r_ex_pc  <= r_id_pc;
      r_mem_pc <= r_ex_pc;
    end
  end

  // Cycle counter runs through freezes; retired count follows retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcycle   <= 64'h0;
      r_minstret <= 64'h0;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
      if (w_retire) begin
        r_minstret <= r_minstret + 64'd1;
      end
    end
  end

  assign PC_IF       = r_pc_if;
  assign ID_PC       = r_id_pc;
  assign EX_PC       = r_ex_pc;
  assign MEM_PC      = r_mem_pc;
  assign ID_invalid  = ~r_id_v;
  assign EX_invalid  = ~r_ex_v;
  assign MEM_invalid = ~r_mem_v;
  assign WB_invalid  = ~r_wb_v;
  assign en_IF_ID    = ~w_freeze & ~stop_ID;
  assign en_ID_EX    = ~w_freeze;
  assign en_EX_MEM   = ~w_freeze;
  assign en_MEM_WB   = ~w_freeze;
  assign retire      = w_retire;
  assign mcycle      = r_mcycle;
  assign minstret    = r_minstret;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_valid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_valid_ctrl
// Description : Directed self-checking bench for pipeline_valid_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_valid_ctrl;

  logic        clk;
  logic        reset;
  logic        set_invalid_IF, set_invalid_ID, set_invalid_EX, set_invalid_MEM;
  logic        stop_IF, stop_ID;
  logic        took_branch, any_excep, ret;
  logic [31:0] branch_target, trap_vector, ret_target;
  logic        imem_ready, dmem_busy;
  logic [31:0] PC_IF, ID_PC, EX_PC, MEM_PC;
  logic        ID_invalid, EX_invalid, MEM_invalid, WB_invalid;
  logic        en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
  logic        retire;
  logic [63:0] mcycle, minstret;

  int n_vec = 0;
  int n_err = 0;

  pipeline_valid_ctrl dut (
    .clk(clk), .reset(reset),
    .set_invalid_IF(set_invalid_IF), .set_invalid_ID(set_invalid_ID),
    .set_invalid_EX(set_invalid_EX), .set_invalid_MEM(set_invalid_MEM),
    .stop_IF(stop_IF), .stop_ID(stop_ID),
    .took_branch(took_branch), .branch_target(branch_target),
    .any_excep(any_excep), .trap_vector(trap_vector),
    .ret(ret), .ret_target(ret_target),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .PC_IF(PC_IF), .ID_PC(ID_PC), .EX_PC(EX_PC), .MEM_PC(MEM_PC),
    .ID_invalid(ID_invalid), .EX_invalid(EX_invalid),
    .MEM_invalid(MEM_invalid), .WB_invalid(WB_invalid),
    .en_IF_ID(en_IF_ID), .en_ID_EX(en_ID_EX),
    .en_EX_MEM(en_EX_MEM), .en_MEM_WB(en_MEM_WB),
    .retire(retire), .mcycle(mcycle), .minstret(minstret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    set_invalid_IF = 0; set_invalid_ID = 0; set_invalid_EX = 0; set_invalid_MEM = 0;
    stop_IF = 0; stop_ID = 0; took_branch = 0; any_excep = 0; ret = 0;
  endtask

  initial begin
    reset = 0; clear_ctl();
    branch_target = 0; trap_vector = 0; ret_target = 0;
    imem_ready = 1; dmem_busy = 0;
    #1 reset = 1;
    tick(); tick();
    chk("rst_pc_if", 64'(PC_IF), 64'h0);
    chk("rst_id_inv", 64'(ID_invalid), 64'd1);
    chk("rst_wb_inv", 64'(WB_invalid), 64'd1);
    chk("rst_mcycle", mcycle, 64'd0);
    chk("rst_minstret", minstret, 64'd0);
    reset = 0;

    // Fill from reset release.
    tick();  // e1
    chk("e1_pc", 64'(PC_IF), 64'h0);
    chk("e1_id_inv", 64'(ID_invalid), 64'd1);
    tick();  // e2
    chk("e2_pc", 64'(PC_IF), 64'h4);
    chk("e2_id_inv", 64'(ID_invalid), 64'd0);
    chk("e2_id_pc", 64'(ID_PC), 64'h0);
    tick();  // e3
    chk("e3_pc", 64'(PC_IF), 64'h8);
    tick(); tick();  // e5
    chk("e5_wb_inv", 64'(WB_invalid), 64'd0);
    chk("e5_retire", 64'(retire), 64'd1);
    tick();  // e6
    chk("e6_minstret", minstret, 64'd1);
    chk("e6_mcycle", mcycle, 64'd6);
    chk("e6_id_pc", 64'(ID_PC), 64'h10);

    // One-cycle stop_IF/stop_ID.
    stop_IF = 1; stop_ID = 1; #1;
    chk("stall_en_if_id", 64'(en_IF_ID), 64'd0);
    chk("stall_en_id_ex", 64'(en_ID_EX), 64'd1);
    tick();  // e7
    clear_ctl();
    chk("e7_pc_hold", 64'(PC_IF), 64'h14);
    chk("e7_id_pc", 64'(ID_PC), 64'h10);
    chk("e7_ex_inv", 64'(EX_invalid), 64'd1);
    chk("e7_id_inv", 64'(ID_invalid), 64'd0);
    tick();  // e8
    chk("e8_pc", 64'(PC_IF), 64'h18);
    chk("e8_ex_pc", 64'(EX_PC), 64'h10);
    chk("e8_mem_inv", 64'(MEM_invalid), 64'd1);
    tick();  // e9
    chk("e9_wb_inv", 64'(WB_invalid), 64'd1);
    chk("e9_retire", 64'(retire), 64'd0);
    chk("e9_minstret", minstret, 64'd4);
    tick();  // e10
    chk("e10_minstret", minstret, 64'd4);
    chk("e10_pc", 64'(PC_IF), 64'h20);

    // Three-cycle freeze, with a branch request ignored in the middle.
    dmem_busy = 1; #1;
    chk("frz_en_mem_wb", 64'(en_MEM_WB), 64'd0);
    chk("frz_en_if_id", 64'(en_IF_ID), 64'd0);
    chk("frz_retire", 64'(retire), 64'd0);
    tick();  // e11
    took_branch = 1; branch_target = 32'h500;
    tick();  // e12
    took_branch = 0;
    tick();  // e13
    chk("frz_pc", 64'(PC_IF), 64'h20);
    chk("frz_id_pc", 64'(ID_PC), 64'h1c);
    chk("frz_mem_pc", 64'(MEM_PC), 64'h14);
    chk("frz_wb_inv", 64'(WB_invalid), 64'd0);
    chk("frz_minstret", minstret, 64'd4);
    chk("frz_mcycle", mcycle, 64'd13);
    dmem_busy = 0;
    tick();  // e14
    chk("e14_pc", 64'(PC_IF), 64'h24);
    chk("e14_minstret", minstret, 64'd5);

    // Taken branch with full flush.
    took_branch = 1; branch_target = 32'h200;
    set_invalid_IF = 1; set_invalid_ID = 1; set_invalid_EX = 1; set_invalid_MEM = 1;
    tick();  // e15
    clear_ctl();
    chk("br_pc", 64'(PC_IF), 64'h200);
    chk("br_id_inv", 64'(ID_invalid), 64'd1);
    chk("br_ex_inv", 64'(EX_invalid), 64'd1);
    chk("br_mem_inv", 64'(MEM_invalid), 64'd1);
    chk("br_wb_inv", 64'(WB_invalid), 64'd1);
    chk("br_minstret", minstret, 64'd6);
    tick();  // e16
    chk("e16_minstret", minstret, 64'd6);
    chk("e16_pc", 64'(PC_IF), 64'h204);
    chk("e16_id_pc", 64'(ID_PC), 64'h200);

    // Redirect priority.
    any_excep = 1; ret = 1; trap_vector = 32'h100; ret_target = 32'h300;
    tick();  // e17
    chk("prio_exc_ret", 64'(PC_IF), 64'h100);
    chk("prio_id_inv", 64'(ID_invalid), 64'd1);
    took_branch = 1; branch_target = 32'h80;
    tick();  // e18
    clear_ctl();
    chk("prio_all", 64'(PC_IF), 64'h80);
    tick();  // e19
    chk("e19_pc", 64'(PC_IF), 64'h84);
    ret = 1; stop_IF = 1;
    tick();  // e20
    clear_ctl();
    chk("ret_over_stop", 64'(PC_IF), 64'h300);
    tick();  // e21
    chk("e21_pc", 64'(PC_IF), 64'h304);

    // PC wrap at 2^32.
    took_branch = 1; branch_target = 32'hFFFF_FFFC;
    tick();  // e22
    clear_ctl();
    chk("wrap_pre", 64'(PC_IF), 64'hFFFF_FFFC);
    tick();  // e23
    chk("wrap_post", 64'(PC_IF), 64'h0);
    tick(); tick(); tick();  // e26: pipeline full again
    chk("full_wb_inv", 64'(WB_invalid), 64'd0);

    // Asynchronous reset pulse between edges.
    #2 reset = 1;
    #1;
    chk("async_pc", 64'(PC_IF), 64'h0);
    chk("async_id_inv", 64'(ID_invalid), 64'd1);
    chk("async_ex_inv", 64'(EX_invalid), 64'd1);
    chk("async_mem_inv", 64'(MEM_invalid), 64'd1);
    chk("async_wb_inv", 64'(WB_invalid), 64'd1);
    chk("async_minstret", minstret, 64'd0);
    chk("async_mcycle", mcycle, 64'd0);
    reset = 0;
    tick();
    chk("rel_pc0", 64'(PC_IF), 64'h0);
    tick();
    chk("rel_pc4", 64'(PC_IF), 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
